// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: the hazard unit,
// the instruction memory, the D-stage decoder/forwarding and the D-stage consumers.
interface fetch_stage_if;
  logic        Stall;
  logic [31:0] instr_f;
  logic        j_if_d;
  logic        jr_if_d;
  logic        Beq_if_d;
  logic        Bne_if_d;
  logic        Bgezal_if_d;
  logic [31:0] rs_val_d;
  logic [31:0] rt_val_d;
  logic [31:0] pc_f;
  logic [31:0] imcode_D;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        taken_d;
  logic        adel_f;

  modport master (
    input  Stall, instr_f, j_if_d, jr_if_d, Beq_if_d, Bne_if_d, Bgezal_if_d,
           rs_val_d, rt_val_d,
    output pc_f, imcode_D, pc_d, pc8_d, taken_d, adel_f
  );

  modport slave (
    output Stall, instr_f, j_if_d, jr_if_d, Beq_if_d, Bne_if_d, Bgezal_if_d,
           rs_val_d, rt_val_d,
    input  pc_f, imcode_D, pc_d, pc8_d, taken_d, adel_f
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register; branches and jumps are
// resolved in D with a single architectural delay slot (no flush).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] imcode_reg;
  logic [31:0] pc_d_reg;
  logic [29:0] sext_imm;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic        eq;
  logic        gez;
  logic        taken;

  // Only 30 bits of the sign-extended immediate survive the shift by two.
  assign sext_imm[15:0] = imcode_reg[15:0];
  genvar gi;
  generate
    for (gi = 16; gi < 30; gi++) begin : g_sext
      assign sext_imm[gi] = imcode_reg[15];
    end
  endgenerate

  assign eq    = (bus.rs_val_d == bus.rt_val_d);
  assign gez   = ~bus.rs_val_d[31];
  assign taken = bus.j_if_d | bus.jr_if_d | (bus.Beq_if_d & eq) |
                 (bus.Bne_if_d & ~eq) | (bus.Bgezal_if_d & gez);

  assign branch_target = pc_d_reg + 32'd4 + {sext_imm, 2'b00};
  assign jump_target   = {pc_d_reg[31:28], imcode_reg[25:0], 2'b00};

  // Decode flags are one-hot, so the order here is not a priority.
  always_comb begin
    target = branch_target;
    if (bus.j_if_d)
      target = jump_target;
    else if (bus.jr_if_d)
      target = bus.rs_val_d;
  end

  always_comb begin
    pc_next = pc_reg + 32'd4;
    if (bus.Stall)
      pc_next = pc_reg;
    else if (taken)
      pc_next = target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg     <= RESET_PC;
      imcode_reg <= 32'd0;
      pc_d_reg   <= 32'd0;
    end else begin
      pc_reg <= pc_next;
      if (!bus.Stall) begin
        imcode_reg <= bus.instr_f;
        pc_d_reg   <= pc_reg;
      end
    end
  end

  assign bus.pc_f     = pc_reg;
  assign bus.imcode_D = imcode_reg;
  assign bus.pc_d     = pc_d_reg;
  assign bus.pc8_d    = pc_d_reg + 32'd8;
  assign bus.taken_d  = taken;
  assign bus.adel_f   = (pc_reg[1:0] != 2'b00);
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios over a small program memory, then
// randomized traffic against an arithmetic model of the fetch/D behaviour.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] prog [0:63];
  logic        use_mem;
  logic [31:0] rand_instr;
  logic [31:0] mem_idx;

  always_comb begin
    mem_idx     = (bus.pc_f - 32'h0000_3000) >> 2;
    bus.instr_f = rand_instr;
    if (use_mem)
      bus.instr_f = (mem_idx < 32'd64) ? prog[mem_idx[5:0]] : 32'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    bus.j_if_d = 0; bus.jr_if_d = 0; bus.Beq_if_d = 0; bus.Bne_if_d = 0;
    bus.Bgezal_if_d = 0; bus.rs_val_d = 0; bus.rt_val_d = 0;
  endtask

  task automatic init_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h2400_0000 + i;
  endtask

  task automatic do_reset();
    reset = 1; bus.Stall = 0; clear_flags();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    init_prog(); use_mem = 1;
    do_reset();
    n_cmp++; if (bus.pc_f !== 32'h3000) begin n_err++; $display("FAIL reset_pc_f: got %h want %h", bus.pc_f, 32'h3000); end
    n_cmp++; if (bus.imcode_D !== 32'h0) begin n_err++; $display("FAIL reset_imcode: got %h want 0", bus.imcode_D); end
    n_cmp++; if (bus.pc_d !== 32'h0) begin n_err++; $display("FAIL reset_pc_d: got %h want 0", bus.pc_d); end
    n_cmp++; if (bus.pc8_d !== 32'h8) begin n_err++; $display("FAIL reset_pc8: got %h want 8", bus.pc8_d); end
    n_cmp++; if (bus.taken_d !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b want 0", bus.taken_d); end
    n_cmp++; if (bus.adel_f !== 1'b0) begin n_err++; $display("FAIL reset_adel: got %b want 0", bus.adel_f); end
    $display("reset: pc_f=%h imcode_D=%h pc_d=%h", bus.pc_f, bus.imcode_D, bus.pc_d);
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    init_prog(); use_mem = 1; do_reset();
    exp_pc = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (bus.pc_f !== exp_pc + 4) begin n_err++; $display("FAIL free_pc_f: got %h want %h", bus.pc_f, exp_pc + 4); end
      n_cmp++; if (bus.pc_d !== exp_pc) begin n_err++; $display("FAIL free_pc_d: got %h want %h", bus.pc_d, exp_pc); end
      n_cmp++; if (bus.imcode_D !== 32'h2400_0000 + i) begin n_err++; $display("FAIL free_imcode: got %h want %h", bus.imcode_D, 32'h2400_0000 + i); end
      n_cmp++; if (bus.pc8_d !== exp_pc + 8) begin n_err++; $display("FAIL free_pc8: got %h want %h", bus.pc8_d, exp_pc + 8); end
      $display("free_run: pc_f=%h pc_d=%h imcode_D=%h", bus.pc_f, bus.pc_d, bus.imcode_D);
      exp_pc = exp_pc + 4;
    end
  endtask

  // Branch-type instruction at 3000 is in D one cycle after reset.
  task automatic load_branch(input logic [31:0] word);
    init_prog(); prog[0] = word; use_mem = 1; do_reset();
    step();
  endtask

  task automatic test_beq();
    logic [31:0] want [2];
    want[0] = 32'h3010; want[1] = 32'h3008;
    for (int k = 0; k < 2; k++) begin
      load_branch({6'b000100, 5'd1, 5'd2, 16'd3});
      bus.Beq_if_d = 1; bus.rs_val_d = 5; bus.rt_val_d = (k == 0) ? 5 : 6;
      #1;
      n_cmp++; if (bus.taken_d !== (k == 0)) begin n_err++; $display("FAIL beq_taken: got %b want %b", bus.taken_d, k == 0); end
      step(); clear_flags();
      n_cmp++; if (bus.pc_f !== want[k]) begin n_err++; $display("FAIL beq_pc_f: got %h want %h", bus.pc_f, want[k]); end
      n_cmp++; if (bus.pc_d !== 32'h3004) begin n_err++; $display("FAIL beq_delay_slot: got %h want 3004", bus.pc_d); end
      step();
      n_cmp++; if (bus.pc_d !== want[k]) begin n_err++; $display("FAIL beq_target_in_d: got %h want %h", bus.pc_d, want[k]); end
      $display("beq rt=%0d: pc_d=%h", (k == 0) ? 5 : 6, bus.pc_d);
    end
    // imm = -1 branches to itself
    load_branch({6'b000100, 5'd1, 5'd2, 16'hFFFF});
    bus.Beq_if_d = 1; bus.rs_val_d = 9; bus.rt_val_d = 9;
    step(); clear_flags();
    n_cmp++; if (bus.pc_f !== 32'h3000) begin n_err++; $display("FAIL beq_self: got %h want 3000", bus.pc_f); end
    $display("beq imm=-1: pc_f=%h", bus.pc_f);
  endtask

  task automatic test_bgezal();
    load_branch({6'b000001, 5'd1, 5'b10001, 16'd2});
    bus.Bgezal_if_d = 1; bus.rs_val_d = 32'h8000_0000;
    #1;
    n_cmp++; if (bus.taken_d !== 1'b0) begin n_err++; $display("FAIL bgezal_neg_taken: got %b want 0", bus.taken_d); end
    n_cmp++; if (bus.pc8_d !== 32'h3008) begin n_err++; $display("FAIL bgezal_pc8: got %h want 3008", bus.pc8_d); end
    step(); clear_flags();
    n_cmp++; if (bus.pc_f !== 32'h3008) begin n_err++; $display("FAIL bgezal_neg_pc: got %h want 3008", bus.pc_f); end
    load_branch({6'b000001, 5'd1, 5'b10001, 16'd2});
    bus.Bgezal_if_d = 1; bus.rs_val_d = 32'h0;
    #1;
    n_cmp++; if (bus.taken_d !== 1'b1) begin n_err++; $display("FAIL bgezal_zero_taken: got %b want 1", bus.taken_d); end
    step(); clear_flags();
    n_cmp++; if (bus.pc_f !== 32'h300C) begin n_err++; $display("FAIL bgezal_zero_pc: got %h want 300c", bus.pc_f); end
    $display("bgezal: pc_f=%h", bus.pc_f);
  endtask

  task automatic test_stall_branch();
    load_branch({6'b000100, 5'd1, 5'd2, 16'd3});
    bus.Beq_if_d = 1; bus.Stall = 1;
    for (int c = 0; c < 2; c++) begin
      bus.rs_val_d = 1; bus.rt_val_d = (c == 0) ? 2 : 1;
      step();
      n_cmp++; if (bus.pc_f !== 32'h3004) begin n_err++; $display("FAIL stall_pc_f: got %h want 3004", bus.pc_f); end
      n_cmp++; if (bus.pc_d !== 32'h3000) begin n_err++; $display("FAIL stall_pc_d: got %h want 3000", bus.pc_d); end
      n_cmp++; if (bus.imcode_D !== {6'b000100, 5'd1, 5'd2, 16'd3}) begin n_err++; $display("FAIL stall_imcode: got %h want 10220003", bus.imcode_D); end
    end
    bus.Stall = 0; bus.rs_val_d = 7; bus.rt_val_d = 7;
    step(); clear_flags();
    n_cmp++; if (bus.pc_f !== 32'h3010) begin n_err++; $display("FAIL stall_release_pc: got %h want 3010", bus.pc_f); end
    n_cmp++; if (bus.pc_d !== 32'h3004) begin n_err++; $display("FAIL stall_release_pc_d: got %h want 3004", bus.pc_d); end
    $display("stall_branch: pc_f=%h pc_d=%h", bus.pc_f, bus.pc_d);
  endtask

  task automatic test_jumps();
    load_branch(32'h0020_0008);
    bus.jr_if_d = 1; bus.rs_val_d = 32'h3022;
    step(); clear_flags();
    n_cmp++; if (bus.pc_f !== 32'h3022) begin n_err++; $display("FAIL jr_pc: got %h want 3022", bus.pc_f); end
    n_cmp++; if (bus.adel_f !== 1'b1) begin n_err++; $display("FAIL jr_adel: got %b want 1", bus.adel_f); end
    load_branch({6'b000010, 26'h000_0C05});
    bus.j_if_d = 1;
    step(); clear_flags();
    n_cmp++; if (bus.pc_f !== 32'h3014) begin n_err++; $display("FAIL j_pc: got %h want 3014", bus.pc_f); end
    // jr to the top of the address space, then wrap on the next fetch
    load_branch(32'h0020_0008);
    bus.jr_if_d = 1; bus.rs_val_d = 32'hFFFF_FFFC;
    step(); clear_flags();
    step();
    n_cmp++; if (bus.pc_f !== 32'h0) begin n_err++; $display("FAIL pc_wrap: got %h want 0", bus.pc_f); end
    n_cmp++; if (bus.adel_f !== 1'b0) begin n_err++; $display("FAIL wrap_adel: got %b want 0", bus.adel_f); end
    $display("jumps: wrap pc_f=%h", bus.pc_f);
  endtask

  task automatic test_reset_override();
    load_branch({6'b000100, 5'd1, 5'd2, 16'd3});
    bus.Beq_if_d = 1; bus.rs_val_d = 3; bus.rt_val_d = 3; bus.Stall = 1; reset = 1;
    step();
    reset = 0; bus.Stall = 0; clear_flags();
    n_cmp++; if (bus.pc_f !== 32'h3000) begin n_err++; $display("FAIL rst_ovr_pc: got %h want 3000", bus.pc_f); end
    n_cmp++; if (bus.imcode_D !== 32'h0) begin n_err++; $display("FAIL rst_ovr_imcode: got %h want 0", bus.imcode_D); end
    $display("reset_override: pc_f=%h imcode_D=%h", bus.pc_f, bus.imcode_D);
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_im, m_pcd, tgt, rs, rt;
    logic        m_taken;
    int          kind;
    int          off;
    use_mem = 0; do_reset();
    m_pc = 32'h3000; m_im = 0; m_pcd = 0;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 7);
      rs = $urandom; if ($urandom_range(0, 1) == 1) rs[31] = 1'b0;
      rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      clear_flags();
      bus.rs_val_d = rs; bus.rt_val_d = rt;
      case (kind)
        0: bus.j_if_d = 1;
        1: bus.jr_if_d = 1;
        2: bus.Beq_if_d = 1;
        3: bus.Bne_if_d = 1;
        4: bus.Bgezal_if_d = 1;
        default: ;
      endcase
      bus.Stall = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 39) == 0);
      rand_instr = $urandom;
      m_taken = (kind == 0) || (kind == 1) || (kind == 2 && rs == rt) ||
                (kind == 3 && rs != rt) || (kind == 4 && $signed(rs) >= 0);
      off = int'($signed(m_im[15:0])) * 4;
      if (kind == 0) tgt = (m_pcd & 32'hF000_0000) | ((m_im & 32'h03FF_FFFF) << 2);
      else if (kind == 1) tgt = rs;
      else tgt = m_pcd + 32'd4 + 32'(off);
      #1;
      n_cmp++; if (bus.taken_d !== m_taken) begin n_err++; $display("FAIL rnd_taken[%0d]: got %b want %b", n, bus.taken_d, m_taken); end
      n_cmp++; if (bus.pc8_d !== m_pcd + 8) begin n_err++; $display("FAIL rnd_pc8[%0d]: got %h want %h", n, bus.pc8_d, m_pcd + 8); end
      n_cmp++; if (bus.adel_f !== (m_pc[1:0] != 0)) begin n_err++; $display("FAIL rnd_adel[%0d]: got %b want %b", n, bus.adel_f, m_pc[1:0] != 0); end
      if (reset) begin
        m_pc = 32'h3000; m_im = 0; m_pcd = 0;
      end else if (!bus.Stall) begin
        m_im = rand_instr; m_pcd = m_pc;
        m_pc = m_taken ? tgt : m_pc + 4;
      end
      step();
      n_cmp++; if (bus.pc_f !== m_pc) begin n_err++; $display("FAIL rnd_pc_f[%0d]: got %h want %h", n, bus.pc_f, m_pc); end
      n_cmp++; if (bus.pc_d !== m_pcd) begin n_err++; $display("FAIL rnd_pc_d[%0d]: got %h want %h", n, bus.pc_d, m_pcd); end
      n_cmp++; if (bus.imcode_D !== m_im) begin n_err++; $display("FAIL rnd_imcode[%0d]: got %h want %h", n, bus.imcode_D, m_im); end
      $display("rnd %0d: kind=%0d stall=%b rst=%b pc_f=%h pc_d=%h", n, kind, bus.Stall, reset, bus.pc_f, bus.pc_d);
    end
    reset = 0; bus.Stall = 0; clear_flags();
  endtask

  initial begin
    reset = 1; bus.Stall = 0; use_mem = 1; rand_instr = 0;
    clear_flags(); init_prog();
    test_reset();
    test_free_run();
    test_beq();
    test_bgezal();
    test_stall_branch();
    test_jumps();
    test_reset_override();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS pipeline. It holds the PC, drives the instruction-memory address and latches the fetched word into the D stage. It resolves branches and jumps in D using the control path's D-stage decode flags and forwarded operands, with one architectural delay slot. It obeys the hazard unit's `Stall`.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.

Ports:
- `clk`, input, 1: the block's single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `Stall`, input, 1: from the hazard unit. Freezes the PC and the IF/ID register.
- `instr_f`, input, 32: instruction word at `pc_f`. Combinational instruction-memory read.
- `j_if_d`, input, 1: D instruction is j or jal.
- `jr_if_d`, input, 1: D instruction is jr.
- `Beq_if_d`, input, 1: D instruction is beq.
- `Bne_if_d`, input, 1: D instruction is bne.
- `Bgezal_if_d`, input, 1: D instruction is bgezal.
- `rs_val_d`, input, 32: forwarded rs operand in D.
- `rt_val_d`, input, 32: forwarded rt operand in D.
- `pc_f`, output, 32: current fetch address.
- `imcode_D`, output, 32: IF/ID instruction register.
- `pc_d`, output, 32: IF/ID PC register.
- `pc8_d`, output, 32: `pc_d + 8`, the link value. Combinational.
- `taken_d`, output, 1: redirect condition for the D instruction. Combinational.
- `adel_f`, output, 1: `pc_f[1:0] != 0`. Fetch-misalignment flag. Combinational.

## Operation

State:
- PC register `pc_f`.
- IF/ID registers `imcode_D` and `pc_d`.

Branch and jump decision in D (combinational):
- `eq = (rs_val_d == rt_val_d)`.
- `gez = ~rs_val_d[31]`.
- `taken_d = j_if_d | jr_if_d | (Beq_if_d & eq) | (Bne_if_d & ~eq) | (Bgezal_if_d & gez)`.
- The decode flags are mutually exclusive. The block does not arbitrate between them.

Targets, all 32-bit with modulo-2^32 wrap:
- Branch: `pc_d + 4 + (sign_ext(imcode_D[15:0]) << 2)`.
- j/jal: `{pc_d[31:28], imcode_D[25:0], 2'b00}`.
- jr: `rs_val_d`, used unmodified. A misaligned value shows up later on `adel_f`.

Next-PC selection, highest priority first:
- `reset`: `RESET_PC`.
- `Stall`: hold `pc_f`.
- `taken_d`: target.
- Otherwise: `pc_f + 4`.

IF/ID update:
- `reset`: `imcode_D = 0` (nop), `pc_d = 0`.
- `Stall`: hold both registers.
- Otherwise: `imcode_D <= instr_f` and `pc_d <= pc_f`.
- There is no flush. The delay-slot instruction always enters D.

Delay slot:
- When a branch is in D, `pc_f == pc_d + 4`, i.e. the delay slot is being fetched.
- The redirect therefore lands on the instruction after the delay slot.

Stall with a branch in D:
- The redirect is suppressed. The PC does not move.
- The branch stays in D and is re-evaluated on every cycle until `Stall` is low, using the operands forwarded in that cycle.
- `taken_d` may toggle while stalled. Only its value in a non-stalled cycle matters.

Link writes (jal, bgezal) use `pc8_d`. For bgezal, `pc8_d` is written regardless of `taken_d`.

## Timing

- Reset values: `pc_f = RESET_PC`, `imcode_D = 0`, `pc_d = 0`, `pc8_d = 8`, `taken_d = 0` (all flags 0 for a nop), `adel_f = 0`.
- Reset asserted mid-stream overrides `Stall` and `taken_d` on the same edge.
- Fetch-to-D latency is 1 cycle. The word at `pc_f` in cycle n is `imcode_D` in cycle n+1.
- Redirect latency: branch in D in cycle n means the target is on `pc_f` in cycle n+1 and in D in cycle n+2. The delay slot is in D in cycle n+1.
- `Stall` acts in the same cycle it is asserted. There is no extra cycle of latency on release.
- PC wrap: `32'hFFFF_FFFC + 4 = 0`, with no flag raised.
- Negative branch offset: `imm = 16'hFFFF` gives target `pc_d`, i.e. the branch to itself works.

## Test plan

- Reset then free-run, `instr_f` = nop, no stall → `pc_f` reads 3000, 3004, 3008 on successive cycles; `imcode_D/pc_d` lag one cycle; `pc8_d = pc_d + 8`.
- beq at 3000, imm=3, rs=rt=5 → delay slot 3004 enters D; next `pc_f = 3010`. Same test with rt=6 → falls through to 3008.
- bgezal with rs=32'h8000_0000 → not taken, `pc8_d` still valid. With rs=0 → taken.
- beq in D with `Stall` high for 2 cycles and operands changing from unequal to equal → PC and IF/ID frozen; redirect happens only on the release cycle, with equal operands.
- jr with rs=32'h0000_3022 → `pc_f = 3022` after the delay slot, `adel_f = 1`. j with index 26'h0000C05 at pc_d=3000 → target 3014.
- Reset asserted while `taken_d = 1` and `Stall = 1` → next cycle `pc_f = 3000`, `imcode_D = 0`.
